skin_blob_tracker: RTL and testbench
====================================

Name: skin_blob_tracker

Overview:
- Consumes the binary skin-mask stream from the grey/threshold stage (iBinary=1 is a skin pixel), qualified by iDVAL and the pixel X/Y counters.
- Per frame, accumulates skin-pixel count, X/Y coordinate sums and the bounding box.
- At each frame boundary, snapshots the totals and computes the integer centroid with a shared serial divider.
- Publishes one result set per frame to the game-logic/overlay stage as a one-cycle valid pulse.

Parameters:
- CNT_W, 22, width of the skin-pixel counter; saturates at all-ones.
- COORD_W, 16, width of coordinates; matches iX_Cont/iY_Cont.
- SUM_W, COORD_W+CNT_W (38), width of the X/Y coordinate accumulators.
- MIN_COUNT, 64, minimum skin-pixel count for a frame to report "found".

Ports:
- iCLK  in  1  single clock; all state on rising edge.
- iRST  in  1  reset, asynchronous, active-low.
- iBinary  in  1  skin mask bit; 1 = skin.
- iDVAL  in  1  pixel qualifier; pixel is used only when 1.
- iX_Cont  in  16  pixel column.
- iY_Cont  in  16  pixel row.
- oCX  out  16  centroid X, floor(sumX/count).
- oCY  out  16  centroid Y, floor(sumY/count).
- oXMin  out  16  bounding box, minimum X.
- oXMax  out  16  bounding box, maximum X.
- oYMin  out  16  bounding box, minimum Y.
- oYMax  out  16  bounding box, maximum Y.
- oCount  out  CNT_W  skin pixels in the frame.
- oFound  out  1  1 when count >= MIN_COUNT.
- oRes_Valid  out  1  one-cycle pulse when result registers update.
- oBusy  out  1  divider active.
- oOverrun  out  1  sticky; set when a frame boundary arrives while busy; cleared only by reset.

Behaviour:
- Reset:
  - All outputs are 0.
  - Accumulators are cleared; min registers are all-ones, max registers are 0.
  - prevY = 0, armed = 0, FSM = ACCUM.
- Frame boundary:
  - A boundary is a cycle with iDVAL=1 and iY_Cont < prevY.
  - prevY updates on every iDVAL=1 cycle.
  - The boundary pixel belongs to the NEW frame.
- Accumulate, on each iDVAL=1 && iBinary=1 non-boundary cycle:
  - count += 1, saturating.
  - sumX += X, sumY += Y.
  - Update min/max.
  - Cycles with iDVAL=0 are ignored regardless of iBinary.
- Snapshot, on the boundary cycle:
  - Live totals copy into snapshot registers.
  - Live registers re-initialise to the boundary pixel's contribution: count 1 / sums X,Y / min=max=X,Y if skin; otherwise count 0 / sums 0 / min all-ones / max 0.
  - If armed=0, the snapshot is discarded and armed is set; the first frame after reset is partial.
  - If the FSM is not in ACCUM, the snapshot is discarded and oOverrun is set.
- FSM:
  - ACCUM -> DIV_X on an accepted snapshot.
  - DIV_X -> DIV_Y on divider done.
  - DIV_Y -> PUBLISH on divider done.
  - PUBLISH -> ACCUM after 1 cycle.
  - Accumulation continues in every state.
- Divider: restoring, 1 quotient bit per cycle, SUM_W cycles per division.
  - Quotient low 16 bits go to oCX/oCY.
  - A zero divisor is never started: if snapshot count < MIN_COUNT, the FSM skips DIV_X/DIV_Y and goes directly to PUBLISH.
- PUBLISH:
  - Registers all outputs and pulses oRes_Valid.
  - If snapshot count >= MIN_COUNT: oFound=1 and the box/centroid/count are presented.
  - Otherwise: oFound=0, oCX/oCY/box = 0, and oCount is still presented.
- Latency:
  - oRes_Valid is high exactly 2*SUM_W+2 cycles after the accepting edge when dividing.
  - It is high 1 cycle after the accepting edge when skipped.
- oBusy is 1 in DIV_X/DIV_Y.
- Outputs hold between pulses.
- Reset mid-division aborts with no pulse; all outputs return to 0.

Decomposition:
- Shared package skin_track_pkg holds:
  - COORD_W, CNT_W and SUM_W defaults.
  - State enum {ACCUM, DIV_X, DIV_Y, PUBLISH}.
  - A result struct (cx, cy, box, count, found).
- One sub-module, seq_divider:
  - Start/done handshake; start is accepted only when idle.
  - Dividend is SUM_W bits, divisor is CNT_W bits.
  - Fixed SUM_W-cycle latency.

Test Plan:
- Reset -> every output 0; oOverrun=0; no oRes_Valid while iDVAL=0.
- Partial-frame discard:
  - Stimulus: 8x4 frames streamed with MIN_COUNT=4 and skin at x=2..5, y=1..2.
  - Required: the first boundary gives no pulse.
- Result check, same stimulus, second boundary:
  - Pulse 78 cycles later.
  - Count=8, CX=3 (28/8), CY=1 (12/8).
  - Box 2..5 / 1..2, oFound=1.
- Below threshold:
  - Stimulus: frame with 3 skin pixels at (1,1),(2,1),(3,1).
  - Required: pulse 1 cycle after boundary; oFound=0, oCount=3, CX=CY=0, box 0.
- iDVAL masking and boundary-pixel ownership:
  - Stimulus: iBinary=1 held with iDVAL=0 for a whole frame, plus a skin pixel at (0,0) on the boundary cycle.
  - Required: that pixel counts in the following frame only (count=1).
- Overrun and reset mid-division:
  - Stimulus: a 2-pixel-tall frame ends while oBusy=1.
  - Required: oOverrun=1 sticky and only one pulse for the two boundaries.
  - Stimulus: iRST low during DIV_Y.
  - Required: no pulse, all outputs 0.

Source files
------------

// File: rtl/skin_track_pkg.sv
// Shared widths, FSM state encoding and the per-frame result record for the
// skin blob tracker.
package skin_track_pkg;

    localparam int unsigned TRK_COORD_W = 16;
    localparam int unsigned TRK_CNT_W   = 22;
    localparam int unsigned TRK_SUM_W   = TRK_COORD_W + TRK_CNT_W;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        DIV_X   = 2'd1,
        DIV_Y   = 2'd2,
        PUBLISH = 2'd3
    } track_state_t;

    typedef struct packed {
        logic [TRK_COORD_W-1:0] x_min;
        logic [TRK_COORD_W-1:0] x_max;
        logic [TRK_COORD_W-1:0] y_min;
        logic [TRK_COORD_W-1:0] y_max;
    } box_t;

    typedef struct packed {
        logic [TRK_COORD_W-1:0] cx;
        logic [TRK_COORD_W-1:0] cy;
        box_t                   box;
        logic [TRK_CNT_W-1:0]   count;
        logic                   found;
    } result_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
// Handshake: i_start is taken only while o_busy is low; the load edge also
// performs the first iteration, and o_done pulses for one cycle when the
// quotient is final, N_W cycles after the accepting edge. The quotient holds
// until the next accepted start.
module seq_divider #(
    parameter int unsigned N_W = 38,
    parameter int unsigned D_W = 22,
    parameter int unsigned Q_W = 16
) (
    input  logic           iCLK,
    input  logic           iRST,
    input  logic           i_start,
    input  logic [N_W-1:0] i_dividend,
    input  logic [D_W-1:0] i_divisor,
    output logic           o_busy,
    output logic           o_done,
    output logic [Q_W-1:0] o_quotient
);

    localparam int unsigned CNT_BITS = $clog2(N_W + 1);

    logic                r_busy;
    logic                r_done;
    logic [CNT_BITS-1:0] r_cnt;
    logic [D_W-1:0]      r_rem;
    logic [N_W-1:0]      r_q;
    logic [D_W-1:0]      r_div;

    logic           w_load;
    logic [D_W-1:0] w_rem_in;
    logic [N_W-1:0] w_q_in;
    logic [D_W-1:0] w_d;
    logic [D_W:0]   w_trial;
    logic           w_fits;
    logic [D_W-1:0] w_diff;
    logic [D_W-1:0] w_rem_nx;
    logic [N_W-1:0] w_q_nx;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits. On the load edge the
    // step works directly on the incoming operands.
    always_comb begin
        w_load   = i_start && !r_busy;
        w_rem_in = w_load ? '0 : r_rem;
        w_q_in   = w_load ? i_dividend : r_q;
        w_d      = w_load ? i_divisor : r_div;
        w_trial  = {w_rem_in, w_q_in[N_W-1]};
        w_fits   = (w_trial >= {1'b0, w_d});
        // The remainder is always below the divisor, so modular D_W-bit
        // subtraction is exact whenever the divisor fits.
        w_diff   = w_trial[D_W-1:0] - w_d;
        w_rem_nx = w_fits ? w_diff : w_trial[D_W-1:0];
        w_q_nx   = {w_q_in[N_W-2:0], w_fits};
    end

    // Iteration counter, operand registers and the done pulse.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_q    <= '0;
            r_div  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_rem  <= w_rem_nx;
                r_q    <= w_q_nx;
                r_div  <= i_divisor;
                r_cnt  <= CNT_BITS'(N_W - 1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_rem_nx;
                r_q   <= w_q_nx;
                r_cnt <= r_cnt - CNT_BITS'(1);
                if (r_cnt == CNT_BITS'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_quotient = r_q[Q_W-1:0];

endmodule

// File: rtl/skin_blob_tracker.sv
// Per-frame skin blob statistics: pixel count, coordinate sums and bounding
// box are accumulated live, snapshotted at each frame boundary, and the
// centroid is computed with one shared serial divider before publishing.
module skin_blob_tracker
    import skin_track_pkg::*;
#(
    parameter int unsigned COORD_W   = TRK_COORD_W,
    parameter int unsigned CNT_W     = TRK_CNT_W,
    parameter int unsigned SUM_W     = COORD_W + CNT_W,
    parameter int unsigned MIN_COUNT = 64
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iBinary,
    input  logic               iDVAL,
    input  logic [COORD_W-1:0] iX_Cont,
    input  logic [COORD_W-1:0] iY_Cont,
    output logic [COORD_W-1:0] oCX,
    output logic [COORD_W-1:0] oCY,
    output logic [COORD_W-1:0] oXMin,
    output logic [COORD_W-1:0] oXMax,
    output logic [COORD_W-1:0] oYMin,
    output logic [COORD_W-1:0] oYMax,
    output logic [CNT_W-1:0]   oCount,
    output logic               oFound,
    output logic               oRes_Valid,
    output logic               oBusy,
    output logic               oOverrun
);

    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_COUNT);

    track_state_t r_state;
    track_state_t w_state_nx;

    logic [COORD_W-1:0] r_prev_y;
    logic               r_armed;
    logic               r_overrun;
    logic               r_go;

    // Live (current frame) accumulators.
    logic [CNT_W-1:0]   r_count;
    logic [SUM_W-1:0]   r_sum_x;
    logic [SUM_W-1:0]   r_sum_y;
    logic [COORD_W-1:0] r_x_min;
    logic [COORD_W-1:0] r_x_max;
    logic [COORD_W-1:0] r_y_min;
    logic [COORD_W-1:0] r_y_max;

    // Totals of the frame being reported.
    logic [CNT_W-1:0]   r_snap_count;
    logic [SUM_W-1:0]   r_snap_sum_x;
    logic [SUM_W-1:0]   r_snap_sum_y;
    logic [COORD_W-1:0] r_snap_x_min;
    logic [COORD_W-1:0] r_snap_x_max;
    logic [COORD_W-1:0] r_snap_y_min;
    logic [COORD_W-1:0] r_snap_y_max;

    logic [COORD_W-1:0] r_qx;
    logic [COORD_W-1:0] r_qy;
    result_t            r_res;
    logic               r_valid;

    logic               w_boundary;
    logic               w_skin;
    logic               w_accept;
    logic               w_big;
    logic               w_snap_big;
    logic               w_div_start;
    logic [SUM_W-1:0]   w_div_dividend;
    logic               w_div_busy;
    logic               w_div_done;
    logic [COORD_W-1:0] w_quot;

    assign w_boundary = iDVAL && (iY_Cont < r_prev_y);
    assign w_skin     = iDVAL && iBinary;
    assign w_accept   = w_boundary && r_armed && (r_state == ACCUM);
    assign w_big      = (r_count >= MIN_CNT);
    assign w_snap_big = (r_snap_count >= MIN_CNT);

    // Row tracking for boundary detection, first-frame arming, sticky overrun.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_prev_y  <= '0;
            r_armed   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (iDVAL) begin
                r_prev_y <= iY_Cont;
            end
            if (w_boundary) begin
                r_armed <= 1'b1;
                if (r_armed && (r_state != ACCUM)) begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    // Live accumulation; the boundary pixel seeds the new frame.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_count <= '0;
            r_sum_x <= '0;
            r_sum_y <= '0;
            r_x_min <= '1;
            r_x_max <= '0;
            r_y_min <= '1;
            r_y_max <= '0;
        end else if (w_boundary) begin
            if (iBinary) begin
                r_count <= CNT_W'(1);
                r_sum_x <= SUM_W'(iX_Cont);
                r_sum_y <= SUM_W'(iY_Cont);
                r_x_min <= iX_Cont;
                r_x_max <= iX_Cont;
                r_y_min <= iY_Cont;
                r_y_max <= iY_Cont;
            end else begin
                r_count <= '0;
                r_sum_x <= '0;
                r_sum_y <= '0;
                r_x_min <= '1;
                r_x_max <= '0;
                r_y_min <= '1;
                r_y_max <= '0;
            end
        end else if (w_skin) begin
            if (r_count != '1) begin
                r_count <= r_count + CNT_W'(1);
            end
            r_sum_x <= r_sum_x + SUM_W'(iX_Cont);
            r_sum_y <= r_sum_y + SUM_W'(iY_Cont);
            if (iX_Cont < r_x_min) r_x_min <= iX_Cont;
            if (iX_Cont > r_x_max) r_x_max <= iX_Cont;
            if (iY_Cont < r_y_min) r_y_min <= iY_Cont;
            if (iY_Cont > r_y_max) r_y_max <= iY_Cont;
        end
    end

    // Snapshot only frames that will actually be reported.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_snap_count <= '0;
            r_snap_sum_x <= '0;
            r_snap_sum_y <= '0;
            r_snap_x_min <= '1;
            r_snap_x_max <= '0;
            r_snap_y_min <= '1;
            r_snap_y_max <= '0;
        end else if (w_accept) begin
            r_snap_count <= r_count;
            r_snap_sum_x <= r_sum_x;
            r_snap_sum_y <= r_sum_y;
            r_snap_x_min <= r_x_min;
            r_snap_x_max <= r_x_max;
            r_snap_y_min <= r_y_min;
            r_snap_y_max <= r_y_max;
        end
    end

    // FSM state register; r_go marks the first DIV_X cycle so the X
    // division starts once the snapshot is in place.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state <= ACCUM;
            r_go    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_go    <= w_accept && w_big;
        end
    end

    // Next state and divider launch; Y starts on the same edge X completes.
    always_comb begin
        w_state_nx     = r_state;
        w_div_start    = 1'b0;
        w_div_dividend = r_snap_sum_x;
        case (r_state)
            ACCUM: begin
                if (w_accept) begin
                    w_state_nx = w_big ? DIV_X : PUBLISH;
                end
            end
            DIV_X: begin
                if (r_go && !w_div_busy) begin
                    w_div_start = 1'b1;
                end
                if (w_div_done) begin
                    w_state_nx     = DIV_Y;
                    w_div_start    = 1'b1;
                    w_div_dividend = r_snap_sum_y;
                end
            end
            DIV_Y: begin
                if (w_div_done) begin
                    w_state_nx = PUBLISH;
                end
            end
            PUBLISH: begin
                w_state_nx = ACCUM;
            end
            default: begin
                w_state_nx = ACCUM;
            end
        endcase
    end

    seq_divider #(
        .N_W (SUM_W),
        .D_W (CNT_W),
        .Q_W (COORD_W)
    ) u_div (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .i_start    (w_div_start),
        .i_dividend (w_div_dividend),
        .i_divisor  (r_snap_count),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_quot)
    );

    // Capture each centroid coordinate as its division completes.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_qx <= '0;
            r_qy <= '0;
        end else begin
            if ((r_state == DIV_X) && w_div_done) r_qx <= w_quot;
            if ((r_state == DIV_Y) && w_div_done) r_qy <= w_quot;
        end
    end

    // Result registers: updated only in PUBLISH, held otherwise.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_res   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (r_state == PUBLISH) begin
                r_valid     <= 1'b1;
                r_res.count <= r_snap_count;
                r_res.found <= w_snap_big;
                if (w_snap_big) begin
                    r_res.cx        <= r_qx;
                    r_res.cy        <= r_qy;
                    r_res.box.x_min <= r_snap_x_min;
                    r_res.box.x_max <= r_snap_x_max;
                    r_res.box.y_min <= r_snap_y_min;
                    r_res.box.y_max <= r_snap_y_max;
                end else begin
                    r_res.cx  <= '0;
                    r_res.cy  <= '0;
                    r_res.box <= '0;
                end
            end
        end
    end

    assign oCX        = r_res.cx;
    assign oCY        = r_res.cy;
    assign oXMin      = r_res.box.x_min;
    assign oXMax      = r_res.box.x_max;
    assign oYMin      = r_res.box.y_min;
    assign oYMax      = r_res.box.y_max;
    assign oCount     = r_res.count;
    assign oFound     = r_res.found;
    assign oRes_Valid = r_valid;
    assign oBusy      = (r_state == DIV_X) || (r_state == DIV_Y);
    assign oOverrun   = r_overrun;

endmodule

// File: tb/tb_skin_blob_tracker.sv
// Directed bench for skin_blob_tracker on 8x4 frames with MIN_COUNT=4.
module tb_skin_blob_tracker;

    localparam int MIN_C = 4;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b0;
    logic        iBinary = 1'b0;
    logic        iDVAL = 1'b0;
    logic [15:0] iX_Cont = '0;
    logic [15:0] iY_Cont = '0;
    logic [15:0] oCX, oCY, oXMin, oXMax, oYMin, oYMax;
    logic [21:0] oCount;
    logic        oFound, oRes_Valid, oBusy, oOverrun;

    skin_blob_tracker #(.MIN_COUNT(MIN_C)) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iBinary    (iBinary),
        .iDVAL      (iDVAL),
        .iX_Cont    (iX_Cont),
        .iY_Cont    (iY_Cont),
        .oCX        (oCX),
        .oCY        (oCY),
        .oXMin      (oXMin),
        .oXMax      (oXMax),
        .oYMin      (oYMin),
        .oYMax      (oYMax),
        .oCount     (oCount),
        .oFound     (oFound),
        .oRes_Valid (oRes_Valid),
        .oBusy      (oBusy),
        .oOverrun   (oOverrun)
    );

    // Clock and cycle counter.
    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    // Pulse monitor: counts result pulses and captures the published set.
    int          pulse_count = 0;
    int          pulse_cyc = 0;
    logic [15:0] cap_cx, cap_cy, cap_xmin, cap_xmax, cap_ymin, cap_ymax;
    logic [21:0] cap_count;
    logic        cap_found;

    always @(negedge iCLK) begin
        if (oRes_Valid) begin
            pulse_count <= pulse_count + 1;
            pulse_cyc   <= cyc;
            cap_cx      <= oCX;
            cap_cy      <= oCY;
            cap_xmin    <= oXMin;
            cap_xmax    <= oXMax;
            cap_ymin    <= oYMin;
            cap_ymax    <= oYMax;
            cap_count   <= oCount;
            cap_found   <= oFound;
        end
    end

    int n_vec = 0;
    int n_fail = 0;
    int b_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Driver tasks.
    task automatic drive(input logic v, input logic b, input int x, input int y);
        @(negedge iCLK);
        iDVAL   = v;
        iBinary = b;
        iX_Cont = 16'(x);
        iY_Cont = 16'(y);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 0, 0);
    endtask

    // Whole 8x4 frame except (0,0), which is supplied as the boundary pixel.
    // With masked set, each pixel is preceded by an iDVAL=0, iBinary=1 cycle.
    task automatic stream_body(input int x0, input int x1, input int y0, input int y1,
                               input bit masked);
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                if (!(x == 0 && y == 0)) begin
                    if (masked) drive(1'b0, 1'b1, x, y);
                    drive(1'b1, (x >= x0 && x <= x1 && y >= y0 && y <= y1), x, y);
                end
            end
        end
    endtask

    task automatic close_frame(input logic b0);
        drive(1'b1, b0, 0, 0);
        b_cyc = cyc + 1;
        drive(1'b0, 1'b0, 0, 0);
    endtask

    task automatic wait_pulses(input int target, input int budget, output bit ok);
        ok = (pulse_count >= target);
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge iCLK);
            #1;
            if (pulse_count >= target) ok = 1'b1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cx"}, oCX, 0);
        check({tag, "_cy"}, oCY, 0);
        check({tag, "_xmin"}, oXMin, 0);
        check({tag, "_xmax"}, oXMax, 0);
        check({tag, "_ymin"}, oYMin, 0);
        check({tag, "_ymax"}, oYMax, 0);
        check({tag, "_count"}, oCount, 0);
        check({tag, "_found"}, oFound, 0);
        check({tag, "_valid"}, oRes_Valid, 0);
        check({tag, "_busy"}, oBusy, 0);
        check({tag, "_overrun"}, oOverrun, 0);
    endtask

    typedef struct {
        int x0, x1, y0, y1;
        int e_count, e_cx, e_cy;
        int e_xmin, e_xmax, e_ymin, e_ymax;
        int e_found, e_lat;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int  p0;
        int  b1;
        bit  ok;

        //            rect x0..x1, y0..y1  cnt cx cy  box               fnd lat
        tbl[0] = '{2, 5, 1, 2,   8, 3, 1,  2, 5, 1, 2,  1, 78};
        tbl[1] = '{1, 3, 1, 1,   3, 0, 0,  0, 0, 0, 0,  0, 1};
        tbl[2] = '{0, 7, 1, 3,  24, 3, 2,  0, 7, 1, 3,  1, 78};
        tbl[3] = '{7, 7, 0, 3,   4, 7, 1,  7, 7, 0, 3,  1, 78};
        tbl[4] = '{1, 6, 3, 3,   6, 3, 3,  1, 6, 3, 3,  1, 78};
        tbl[5] = '{1, 0, 1, 0,   0, 0, 0,  0, 0, 0, 0,  0, 1};

        // Reset state.
        repeat (3) @(negedge iCLK);
        check_all_zero("reset");
        iRST = 1'b1;
        idle(5);
        check("idle_no_pulse", pulse_count, 0);

        // First boundary after reset closes a partial frame: no pulse.
        p0 = pulse_count;
        drive(1'b1, 1'b0, 0, 0);
        stream_body(2, 5, 1, 2, 1'b0);
        close_frame(1'b0);
        idle(100);
        check("partial_discard", pulse_count, p0);

        // Table of full frames.
        foreach (tbl[i]) begin
            p0 = pulse_count;
            stream_body(tbl[i].x0, tbl[i].x1, tbl[i].y0, tbl[i].y1, 1'b0);
            close_frame(1'b0);
            wait_pulses(p0 + 1, 200, ok);
            check($sformatf("v%0d_pulse_seen", i), ok, 1);
            check($sformatf("v%0d_latency", i), pulse_cyc - b_cyc, tbl[i].e_lat);
            check($sformatf("v%0d_count", i), cap_count, tbl[i].e_count);
            check($sformatf("v%0d_cx", i), cap_cx, tbl[i].e_cx);
            check($sformatf("v%0d_cy", i), cap_cy, tbl[i].e_cy);
            check($sformatf("v%0d_xmin", i), cap_xmin, tbl[i].e_xmin);
            check($sformatf("v%0d_xmax", i), cap_xmax, tbl[i].e_xmax);
            check($sformatf("v%0d_ymin", i), cap_ymin, tbl[i].e_ymin);
            check($sformatf("v%0d_ymax", i), cap_ymax, tbl[i].e_ymax);
            check($sformatf("v%0d_found", i), cap_found, tbl[i].e_found);
            idle(3);
            check($sformatf("v%0d_hold_count", i), oCount, tbl[i].e_count);
            check($sformatf("v%0d_one_pulse", i), pulse_count, p0 + 1);
        end

        // iDVAL masking: iBinary=1 on invalid cycles never counts; skin on
        // the boundary pixel belongs to the following frame.
        p0 = pulse_count;
        stream_body(1, 0, 1, 0, 1'b1);
        close_frame(1'b1);
        wait_pulses(p0 + 1, 200, ok);
        check("mask_pulse_seen", ok, 1);
        check("mask_count", cap_count, 0);
        check("mask_latency", pulse_cyc - b_cyc, 1);
        p0 = pulse_count;
        stream_body(1, 0, 1, 0, 1'b0);
        close_frame(1'b0);
        wait_pulses(p0 + 1, 200, ok);
        check("bpix_pulse_seen", ok, 1);
        check("bpix_count", cap_count, 1);
        check("bpix_found", cap_found, 0);
        check("bpix_cx", cap_cx, 0);

        // Overrun: a 2-row frame ends while the divider is still busy.
        check("pre_overrun", oOverrun, 0);
        p0 = pulse_count;
        stream_body(2, 5, 1, 2, 1'b0);
        close_frame(1'b0);
        b1 = b_cyc;
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 8; x++) begin
                if (!(x == 0 && y == 0)) drive(1'b1, 1'b0, x, y);
            end
        end
        check("ovr_busy_at_boundary", oBusy, 1);
        close_frame(1'b0);
        idle(2);
        check("ovr_set", oOverrun, 1);
        wait_pulses(p0 + 1, 200, ok);
        check("ovr_pulse_seen", ok, 1);
        check("ovr_latency", pulse_cyc - b1, 78);
        check("ovr_count", cap_count, 8);
        check("ovr_cx", cap_cx, 3);
        idle(100);
        check("ovr_single_pulse", pulse_count, p0 + 1);
        check("ovr_sticky", oOverrun, 1);

        // Reset in the middle of the Y division.
        p0 = pulse_count;
        stream_body(2, 5, 1, 2, 1'b0);
        close_frame(1'b0);
        idle(50);
        check("rst_mid_busy", oBusy, 1);
        check("rst_mid_prev_found", oFound, 1);
        @(negedge iCLK);
        iRST = 1'b0;
        repeat (2) @(negedge iCLK);
        check_all_zero("rst_mid");
        iRST = 1'b1;
        idle(100);
        check("rst_mid_no_pulse", pulse_count, p0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
